// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, glyph table and scan state type for seg_scan_ctrl
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments g..a for hex digits 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex nibble to active-low 7-segment glyph
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller, frame-aligned word commit (optional SEG_LZ_BLANK_EN)
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    input  logic                  blank_all,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    seg_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [4*DIGITS-1:0]   display_q;
    logic [4*DIGITS-1:0]   pending_q;
    logic                  pending_full_q;
    logic                  load_ready_q;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  tick_q;

    logic                  slot_end;
    logic                  frame_end;
    logic                  xfer;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_glyph;
    logic                  digit_vis;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign xfer      = load_valid && load_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (slot_end) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK: begin
                if (BLANK_CYC == 0 || cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_end && BLANK_CYC != 0) begin
                    state_d = BLANK;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // A word waits in pending until the frame boundary so a scan never mixes old and new digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            load_ready_q   <= 1'b1;
        end else begin
            if (frame_end && pending_full_q) begin
                display_q      <= pending_q;
                pending_full_q <= 1'b0;
                load_ready_q   <= 1'b1;
            end
            if (xfer) begin
                pending_q      <= load_data;
                pending_full_q <= 1'b1;
                load_ready_q   <= 1'b0;
            end
        end
    end

    assign cur_nibble = display_q[{idx_q, 2'b00} +: 4];

    seg_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (cur_glyph)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_show;

    // Scan from the top digit down; a digit shows once any nibble at or above it is nonzero
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_show = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (display_q[4*i +: 4] != 4'h0);
            lz_show[i] = seen || (i == 0);
        end
    end

    assign digit_vis = lz_show[idx_q];
`else
    assign digit_vis = 1'b1;
`endif

    always_comb begin
        seg_d = SEG_OFF;
        dig_d = '1;
        if (state_q == DRIVE && !blank_all && digit_vis) begin
            seg_d = cur_glyph;
            for (int i = 0; i < DIGITS; i++) begin
                dig_d[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_OFF;
            dig_q  <= '1;
            tick_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            dig_q  <= dig_d;
            tick_q <= frame_end;
        end
    end

    assign seg_n      = seg_q;
    assign dig_n      = dig_q;
    assign frame_tick = tick_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        blank_all = 1'b0;
    logic        load_ready;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_all  (blank_all),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       ready;
        logic       tick;
    } obs_t;

    typedef struct {
        logic [15:0] data;
        logic [6:0]  seg [4];
    } vec_t;

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    obs_t        exp_q [$];
    vec_t        vecs [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_pos = 0;
    int          last_pos = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model predicts the outputs produced by this cycle, DUT is sampled on the following negedge
    task automatic cyc();
        obs_t e;
        obs_t got;
        int   c, s;
        logic on, xfer;
        c  = m_pos % SCAN_DIV;
        s  = m_pos / SCAN_DIV;
        on = (c >= BLANK_CYC) && !blank_all;
`ifdef SEG_LZ_BLANK_EN
        on = on && ((s == 0) || ((m_disp >> (4*s)) != 16'h0));
`endif
        e.seg  = on ? gl[m_disp[4*s +: 4]] : 7'h7F;
        e.dig  = on ? ~(4'b0001 << s) : 4'hF;
        e.tick = (m_pos == FRAME - 1);
        xfer   = load_valid && !m_full;
        if (m_pos == FRAME - 1 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (xfer) begin
            m_pend = load_data;
            m_full = 1'b1;
        end
        e.ready = !m_full;
        exp_q.push_back(e);
        last_pos = m_pos;
        m_pos    = (m_pos + 1) % FRAME;
        @(posedge clk);
        @(negedge clk);
        got = {seg_n, dig_n, load_ready, frame_tick};
        if (exp_q.size() == 0) begin
            check("scoreboard empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("outputs at pos %0d", last_pos), got, e);
        end
    endtask

    task automatic run_to(input int p);
        while (m_pos != p) cyc();
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        cyc();
        load_valid = 1'b0;
    endtask

    initial begin
        int ticks;
        logic [3:0] edig;

        vecs[0].data = 16'h12AF; vecs[0].seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        vecs[1].data = 16'h9C5B; vecs[1].seg = '{7'h03, 7'h12, 7'h46, 7'h10};
`ifdef SEG_LZ_BLANK_EN
        vecs[2].data = 16'h00A0; vecs[2].seg = '{7'h40, 7'h08, 7'h7F, 7'h7F};
`else
        vecs[2].data = 16'h00A0; vecs[2].seg = '{7'h40, 7'h08, 7'h40, 7'h40};
`endif
        vecs[3].data = 16'h8E7D; vecs[3].seg = '{7'h21, 7'h78, 7'h06, 7'h00};

        repeat (2) begin
            @(negedge clk);
            check("reset outputs", {seg_n, dig_n, load_ready, frame_tick}, {7'h7F, 4'hF, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        #1;
        check("after release", {seg_n, dig_n, load_ready, frame_tick}, {7'h7F, 4'hF, 1'b1, 1'b0});

        // Each word loaded mid-frame must appear intact in the frame after its commit
        for (int v = 0; v < 4; v++) begin
            run_to(3);
            load_word(vecs[v].data);
            run_to(0);
            for (int k = 0; k < FRAME; k++) begin
                cyc();
                if (last_pos % SCAN_DIV == 4) begin
                    edig = (vecs[v].seg[last_pos / SCAN_DIV] == 7'h7F) ? 4'hF
                           : ~(4'b0001 << (last_pos / SCAN_DIV));
                    check($sformatf("vec %0d slot %0d seg", v, last_pos / SCAN_DIV),
                          seg_n, vecs[v].seg[last_pos / SCAN_DIV]);
                    check($sformatf("vec %0d slot %0d dig", v, last_pos / SCAN_DIV), dig_n, edig);
                end
            end
        end

        run_to(10);
        load_word(16'h1111);
        load_valid = 1'b1;
        load_data  = 16'h2222;
        repeat (8) begin
            cyc();
            check("ready held low", load_ready, 0);
        end
        load_valid = 1'b0;
        run_to(0);
        check("ready after commit", load_ready, 1);
        run_to(5);
        check("tear-free slot0 seg", {seg_n, dig_n}, {7'h79, 4'hE});

        run_to(FRAME - 1);
        load_word(16'h3333);
        run_to(5);
        check("simultaneous old word", seg_n, 7'h79);
        run_to(0);
        run_to(5);
        check("simultaneous new word", seg_n, 7'h30);

        run_to(0);
        blank_all = 1'b1;
        ticks = 0;
        repeat (40) begin
            cyc();
            check("blank_all dark", {seg_n, dig_n}, {7'h7F, 4'hF});
            if (frame_tick) ticks++;
        end
        blank_all = 1'b0;
        check("ticks under blank_all", ticks, 1);

        run_to(2);
        load_word(16'h4444);
        run_to(5);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {seg_n, dig_n, load_ready, frame_tick}, {7'h7F, 4'hF, 1'b1, 1'b0});
        @(posedge clk);
        @(negedge clk);
        check("held reset outputs", {seg_n, dig_n, load_ready, frame_tick}, {7'h7F, 4'hF, 1'b1, 1'b0});
        rst_n  = 1'b1;
        m_pos  = 0;
        m_disp = '0;
        m_full = 1'b0;
        exp_q.delete();
        run_to(5);
        check("post-reset display zero", {seg_n, dig_n}, {7'h40, 4'hE});
        run_to(0);
        run_to(5);
        check("pending discarded", {seg_n, dig_n}, {7'h40, 4'hE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed controller for a bank of common-anode 7-segment digits.
- Holds a DIGITS-nibble display word and scans one digit slot at a time through a single shared hex-to-segment decoder.
- New display words are accepted by a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the system status/debug logic and the board LED pins.

Parameters:
- DIGITS, 4: number of digit positions (>=1); digit 0 is the least significant nibble.
- SCAN_DIV, 1000: clocks per digit slot (> BLANK_CYC).
- BLANK_CYC, 16: dead-time clocks at the start of each slot, with all digits off (anti-ghosting); 0 allowed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- load_valid  in  1  new display word offered
- load_data  in  4*DIGITS  nibble i at bits [4i+3:4i]
- load_ready  out  1  controller can accept a word
- blank_all  in  1  force the display dark
- seg_n  out  7  segments g..a, active-low
- dig_n  out  DIGITS  digit enables, active-low, one-hot-low when driving
- frame_tick  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - seg_n=7'h7F, dig_n all 1, load_ready=1, frame_tick=0.
  - Display register=0, pending register empty, slot counter cnt=0, digit index idx=0, state BLANK.
- Counters:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0 and advances idx.
  - idx wraps from DIGITS-1 to 0.
- State machine, per slot:
  - BLANK while cnt<BLANK_CYC.
  - DRIVE for the rest of the slot.
  - BLANK->DRIVE when cnt==BLANK_CYC-1. With BLANK_CYC=0, BLANK is skipped.
  - DRIVE->BLANK when cnt==SCAN_DIV-1.
- Outputs: registered, one cycle after the state/cnt/idx that produced them.
  - BLANK: dig_n all 1, seg_n 7'h7F.
  - DRIVE: dig_n = ~(1<<idx), seg_n = decode(display[idx]).
- Decode table (active-low g..a):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Handshake:
  - A transfer occurs when load_valid && load_ready; load_data is captured into the pending register.
  - load_ready drops the cycle after a transfer.
- Frame end (cnt==SCAN_DIV-1 and idx==DIGITS-1):
  - frame_tick is asserted on the next cycle for exactly one cycle.
  - If pending is full, pending is copied into the display register and pending is emptied.
  - load_ready returns to 1 on the cycle after the commit.
  - The new word is first visible in the next frame's slot 0.
- Boundary cases:
  - Transfer on the same cycle as frame end with pending empty: the word waits for the following frame end; it is never committed the same cycle.
  - load_valid while load_ready=0: ignored; no data loss inside the block (the producer holds the word).
- blank_all: forces the BLANK output pattern from the next cycle. Counters, commits and frame_tick continue unchanged.
- rst_n asserted mid-slot or mid-handshake: every value returns to reset immediately; the pending word is discarded.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit is treated as BLANK in its DRIVE phase if it and every higher-index digit are 0.
  - Digit 0 is always shown.
  - Suppression is computed from the committed display register.
- Undefined: every digit is always shown; no extra logic.

Decomposition:
- Shared package seg_pkg:
  - Constants SEG_OFF=7'h7F and the 16-entry glyph table.
  - State enum {BLANK, DRIVE}.
- One natural sub-module, seg_decode: combinational 4-bit nibble -> 7-bit active-low glyph, instantiated once.

Test Plan (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2):
- Reset: hold rst_n=0 -> seg_n=7F, dig_n=F, load_ready=1, frame_tick=0. After release, frame_tick first pulses 32 cycles later and then every 32 cycles.
- Scan content: load 16'h12AF before the first frame end -> next frame shows:
  - slot 0: dig_n=E, seg_n=0E
  - slot 1: dig_n=D, seg_n=08
  - slot 2: dig_n=B, seg_n=24
  - slot 3: dig_n=7, seg_n=79
  - Each slot has 2 dark cycles first.
- Tear-free commit: load 16'h1111 mid-frame, then offer 16'h2222 -> load_ready stays 0 and 2222 is not accepted. 1111 appears only from the next frame's slot 0; load_ready returns 1 the cycle after the commit.
- Simultaneous: a transfer on the frame-end cycle is displayed one full frame later, not immediately.
- blank_all=1 for 40 cycles -> seg_n=7F and dig_n=F throughout, while frame_tick keeps pulsing every 32 cycles.
- SEG_LZ_BLANK_EN defined, load 16'h00A0 -> digits 3 and 2 dark, digit 1 seg_n=08, digit 0 seg_n=40.
- Reset mid-slot: rst_n=0 at cnt=5 -> outputs return to reset values immediately.
